link_tx_credit: RTL and testbench
=================================

Name: link_tx_credit

Overview:
- Transmit side of one router output link (N/E/W/S/L); the downstream end of the ready-based flow control.
- Accepts flits from the crossbar with a valid/ready handshake and registers them onto the link toward the neighbour's input FIFO.
- Tracks free slots in the neighbour's FIFO with a credit counter. Drives the per-port ready level that flowcontrol consumes as Xready_in.

Parameters:
- DATA_WIDTH, 32, flit width in bits.
- CREDITS, 4, depth of the downstream input FIFO, which is also the initial credit count. Legal range 1..(2**CNT_WIDTH)-1.
- CNT_WIDTH, 3, width of the credit counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  crossbar has a flit for this port.
- in_data  input  DATA_WIDTH  flit from the crossbar.
- in_ready  output  1  flit is accepted on the rising edge where in_valid && in_ready.
- link_valid  output  1  one-cycle strobe: link_data is a new flit.
- link_data  output  DATA_WIDTH  registered flit to the neighbour.
- credit_in  input  1  one-cycle pulse from the neighbour: one FIFO slot freed.
- ready_out  output  1  level to flowcontrol, high when credits > 0.
- credit_cnt  output  CNT_WIDTH  current credit count, for debug and verification.
- credit_err  output  1  sticky credit overflow/underflow error flag.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - credit_cnt=CREDITS, link_valid=0, link_data=0, credit_err=0.
  - Hence in_ready=1 and ready_out=1 while in reset and after release.
- in_ready = ready_out = (credit_cnt != 0). Both are purely a function of registered credit_cnt.
  - No combinational path from credit_in or in_valid to in_ready.
- Accept = in_valid && in_ready, sampled at rising edge k. Then, during cycle k+1:
  - link_valid=1 and link_data=in_data.
  - Fixed latency of 1 cycle.
- No accept at an edge: link_valid=0 for the next cycle and link_data holds its last value.
- Back-to-back accepts give link_valid high on consecutive cycles, one flit per cycle, throughput 1 flit/clk while credits last.
- Credit counter update per edge:
  - accept only: cnt-1.
  - credit_in only: cnt+1.
  - both in the same cycle: cnt unchanged.
  - neither: unchanged.
- Empty (cnt==0):
  - in_ready=0, so no accept; in_data is ignored even when in_valid=1.
  - A credit_in at cnt==0 raises cnt to 1. in_ready rises the following cycle, giving a 1-cycle credit-return-to-accept latency.
- Overflow (credit_in while cnt==CREDITS with no simultaneous accept):
  - cnt saturates at CREDITS.
  - credit_err set at that edge and held until reset.
- Underflow cannot occur through the handshake.
- Counter arithmetic uses CNT_WIDTH bits and never wraps, by saturation at both ends.
- Reset asserted mid-transfer:
  - Any flit in the output register is dropped (link_valid=0 immediately).
  - Credits restore to CREDITS. The downstream FIFO is reset in the same domain at the same time.
- in_data is captured only on accept. It need not be stable otherwise.

Test Plan:
- Reset check: hold rst=0 for 2 cycles, release. Required: credit_cnt=4, in_ready=1, ready_out=1, link_valid=0, credit_err=0.
- Burst to exhaustion: in_valid=1 with data 0xA0..0xA5 on 6 consecutive cycles, no credit_in.
  - Required: link_valid high for exactly 4 cycles carrying 0xA0..0xA3, each one cycle after its accept.
  - credit_cnt steps 3,2,1,0; in_ready=0 and ready_out=0 after the 4th accept; 0xA4 is held off.
- Credit return at zero: from cnt=0 pulse credit_in once while in_valid=1 with data 0xA4.
  - Required: cnt=1 the next cycle with in_ready=1.
  - 0xA4 accepted at the following edge; cnt back to 0; link_data=0xA4 with link_valid=1 one cycle later.
- Simultaneous events: at cnt=2, assert accept and credit_in in the same cycle for 3 cycles (data 0x11,0x22,0x33).
  - Required: cnt stays 2 throughout; three consecutive link_valid strobes with 0x11,0x22,0x33.
- Overflow: at cnt=4 pulse credit_in with in_valid=0.
  - Required: cnt stays 4; credit_err=1 and remains 1 after a further 10 idle cycles; cleared only by rst=0.
- Async reset mid-burst: at cnt=1 with link_valid=1, drive rst=0 between clock edges.
  - Required: link_valid=0 and cnt=4 immediately, before the next edge; normal accepts resume after release.

Source files
------------

// File: rtl/link_tx_credit.sv
// Transmit side of one router output link: registers accepted flits onto the
// link and tracks free slots in the neighbour's input FIFO with a credit counter.
module link_tx_credit #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  link_valid,
  output logic [DATA_WIDTH-1:0] link_data,
  input  logic                  credit_in,
  output logic                  ready_out,
  output logic [CNT_WIDTH-1:0]  credit_cnt,
  output logic                  credit_err
);

  localparam logic [CNT_WIDTH-1:0] CREDITS_C = CNT_WIDTH'(CREDITS);

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  link_valid_q;
  logic [DATA_WIDTH-1:0] link_data_q;
  logic                  ready;
  logic                  accept;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (c == CREDITS_C) return c;
    return c + CNT_WIDTH'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_dec(input logic [CNT_WIDTH-1:0] c);
    if (c == '0) return c;
    return c - CNT_WIDTH'(1);
  endfunction

  // Ready depends only on the registered count, never on credit_in or in_valid.
  assign ready  = (cnt_q != '0);
  assign accept = in_valid && ready;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({accept, credit_in})
      2'b10: cnt_d = sat_dec(cnt_q);
      2'b01: begin
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == CREDITS_C) err_d = 1'b1;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= CREDITS_C;
      err_q        <= 1'b0;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      link_valid_q <= accept;
      if (accept) link_data_q <= in_data;
    end
  end

  assign in_ready   = ready;
  assign ready_out  = ready;
  assign link_valid = link_valid_q;
  assign link_data  = link_data_q;
  assign credit_cnt = cnt_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_link_tx_credit.sv
// Directed bench for link_tx_credit: vector table plus hand-written
// sequences for sticky error and asynchronous reset.
module tb_link_tx_credit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        link_valid;
  logic [31:0] link_data;
  logic        credit_in;
  logic        ready_out;
  logic [2:0]  credit_cnt;
  logic        credit_err;

  int total = 0;
  int passed = 0;

  link_tx_credit #(.DATA_WIDTH(32), .CREDITS(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .link_valid(link_valid), .link_data(link_data),
    .credit_in(credit_in), .ready_out(ready_out),
    .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        c;
    logic [2:0]  cnt;
    logic        rdy;
    logic        lv;
    logic [31:0] ld;
    logic        err;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] d, logic c, logic [2:0] cnt,
                              logic rdy, logic lv, logic [31:0] ld, logic err);
    vec_t r;
    r.v = v; r.d = d; r.c = c; r.cnt = cnt;
    r.rdy = rdy; r.lv = lv; r.ld = ld; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] cnt, input logic rdy,
                           input logic lv, input logic [31:0] ld, input logic err);
    chk({tag, ".cnt"}, 32'(credit_cnt), 32'(cnt));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, ".ready_out"}, 32'(ready_out), 32'(rdy));
    chk({tag, ".link_valid"}, 32'(link_valid), 32'(lv));
    chk({tag, ".link_data"}, link_data, ld);
    chk({tag, ".err"}, 32'(credit_err), 32'(err));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    // burst to exhaustion
    vecs[0]  = mk(1, 32'hA0, 0, 3, 1, 1, 32'hA0, 0);
    vecs[1]  = mk(1, 32'hA1, 0, 2, 1, 1, 32'hA1, 0);
    vecs[2]  = mk(1, 32'hA2, 0, 1, 1, 1, 32'hA2, 0);
    vecs[3]  = mk(1, 32'hA3, 0, 0, 0, 1, 32'hA3, 0);
    vecs[4]  = mk(1, 32'hA4, 0, 0, 0, 0, 32'hA3, 0);
    vecs[5]  = mk(1, 32'hA5, 0, 0, 0, 0, 32'hA3, 0);
    // credit return at zero
    vecs[6]  = mk(1, 32'hA4, 1, 1, 1, 0, 32'hA3, 0);
    vecs[7]  = mk(1, 32'hA4, 0, 0, 0, 1, 32'hA4, 0);
    // refill to 2, then simultaneous accept + credit
    vecs[8]  = mk(0, 32'hFF, 1, 1, 1, 0, 32'hA4, 0);
    vecs[9]  = mk(0, 32'hFF, 1, 2, 1, 0, 32'hA4, 0);
    vecs[10] = mk(1, 32'h11, 1, 2, 1, 1, 32'h11, 0);
    vecs[11] = mk(1, 32'h22, 1, 2, 1, 1, 32'h22, 0);
    vecs[12] = mk(1, 32'h33, 1, 2, 1, 1, 32'h33, 0);
    // refill to 4, then overflow
    vecs[13] = mk(0, 32'h00, 1, 3, 1, 0, 32'h33, 0);
    vecs[14] = mk(0, 32'h00, 1, 4, 1, 0, 32'h33, 0);
    vecs[15] = mk(0, 32'h00, 1, 4, 1, 0, 32'h33, 1);

    rst = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; credit_in = 1'b0;
    step(); step();
    chk_state("in_reset", 3'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk_state("after_reset", 3'd4, 1'b1, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      in_valid = vecs[i].v; in_data = vecs[i].d; credit_in = vecs[i].c;
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].rdy, vecs[i].lv, vecs[i].ld, vecs[i].err);
    end

    // error flag is sticky across idle cycles
    in_valid = 1'b0; credit_in = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk_state("err_sticky", 3'd4, 1'b1, 1'b0, 32'h33, 1'b1);

    // accept and credit together at full count: no error, no change
    rst = 1'b0; #1;
    chk_state("err_clear", 3'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'h55; credit_in = 1'b1;
    step();
    chk_state("full_both", 3'd4, 1'b1, 1'b1, 32'h55, 1'b0);

    // drive count down to 1 with a flit on the link
    credit_in = 1'b0;
    in_data = 32'hB0; step();
    in_data = 32'hB1; step();
    in_data = 32'hB2; step();
    chk_state("pre_async", 3'd1, 1'b1, 1'b1, 32'hB2, 1'b0);

    // asynchronous reset between edges takes effect before the next edge
    #2;
    rst = 1'b0;
    #1;
    chk_state("async_rst", 3'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'hC0;
    step();
    chk_state("resume", 3'd3, 1'b1, 1'b1, 32'hC0, 1'b0);
    in_valid = 1'b0;
    step();
    chk_state("resume_idle", 3'd3, 1'b1, 1'b0, 32'hC0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
